// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic cells.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// Combinational full subtractor: d = x - y - bin, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  // Stage 1 subtracts y from x, stage 2 subtracts the incoming borrow.
  assign d1 = x ^ y;
  assign b1 = ~x & y;
  assign d  = d1 ^ bin;
  assign b2 = ~d1 & bin;
  assign bo = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is accepted on any edge where busy = 0 (IDLE or DONE);
  // a and b are captured on that edge. done pulses for exactly one cycle and
  // diff/b_out are valid from then until the next accepted start.

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             borrow_ff;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor u_fs (
    .x   (sh_a[0]),
    .y   (sh_b[0]),
    .bin (borrow_ff),
    .d   (d_bit),
    .bo  (bo_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      diff_q    <= '0;
      cnt       <= '0;
      borrow_ff <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      b_out     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sh_a      <= a;
            sh_b      <= b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          sh_a      <= sh_a >> 1;
          sh_b      <= sh_b >> 1;
          // Result bits enter at the MSB so bit i settles at diff[i].
          diff_q    <= {d_bit, diff_q[WIDTH-1:1]};
          borrow_ff <= bo_bit;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            b_out <= bo_bit;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign diff = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised bench for serial_subtractor with 4- and 8-bit builds.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, b_out4;
  logic [3:0] diff4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, b_out8;
  logic [7:0] diff8;

  logic [4:0] exp_q4[$];
  logic [8:0] exp_q8[$];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt4 = 0;
  int done_cnt8 = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(b_out4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(b_out8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst && done4) begin
      done_cnt4++;
      if (exp_q4.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL res4_unexpected: got %0h expected no done", {b_out4, diff4});
      end else begin
        check("res4", {27'd0, b_out4, diff4}, {27'd0, exp_q4.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      done_cnt8++;
      if (exp_q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL res8_unexpected: got %0h expected no done", {b_out8, diff8});
      end else begin
        check("res8", {23'd0, b_out8, diff8}, {23'd0, exp_q8.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called on the negedge where start was raised; lat counts negedges until done.
  task automatic wait_done4(input bit clr, output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      lat = i;
      if (clr && i == 1) start4 = 1'b0;
      if (done4) return;
      if (busy4) bcnt++;
    end
    n_cmp++;
    n_err++;
    $display("FAIL done4_timeout: got no done expected done within 40 cycles");
  endtask

  task automatic wait_done8(input bit clr, output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      lat = i;
      if (clr && i == 1) start8 = 1'b0;
      if (done8) return;
      if (busy8) bcnt++;
    end
    n_cmp++;
    n_err++;
    $display("FAIL done8_timeout: got no done expected done within 40 cycles");
  endtask

  task automatic run8(input logic [7:0] ra, input logic [7:0] rb);
    int lat, bcnt;
    logic [7:0] rd;
    rd = ra - rb;
    @(negedge clk);
    a8 = ra;
    b8 = rb;
    start8 = 1'b1;
    exp_q8.push_back({(ra < rb), rd});
    wait_done8(1'b1, lat, bcnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bcnt, base;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy8",  {31'd0, busy8},  32'd0);
    check("reset_done8",  {31'd0, done8},  32'd0);
    check("reset_diff8",  {24'd0, diff8},  32'd0);
    check("reset_bout8",  {31'd0, b_out8}, 32'd0);
    check("reset_out4",   {26'd0, busy4, done4, b_out4, diff4[2:0]}, 32'd0);

    // 1: 9 - 3 = 6, busy 4 cycles, done 5 negedges after start raised
    a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
    exp_q4.push_back({1'b0, 4'd6});
    wait_done4(1'b1, lat, bcnt);
    check("t1_latency", lat, 32'd5);
    check("t1_busy_cycles", bcnt, 32'd4);
    @(negedge clk);
    check("t1_done_one_cycle", {31'd0, done4}, 32'd0);

    // 2: 3 - 9 = 0xA with borrow, held for 10 idle cycles
    a4 = 4'd3; b4 = 4'd9; start4 = 1'b1;
    exp_q4.push_back({1'b1, 4'hA});
    wait_done4(1'b1, lat, bcnt);
    a4 = 4'd5; b4 = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_hold", {27'd0, b_out4, diff4}, {27'd0, 1'b1, 4'hA});
    end

    // 3: 15 - 15 then 0 - 0 with start held high, period WIDTH+1
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    exp_q4.push_back(5'd0);
    exp_q4.push_back(5'd0);
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0;
    wait_done4(1'b0, lat, bcnt);
    check("t3_first_latency", lat, 32'd4);
    wait_done4(1'b1, lat, bcnt);
    check("t3_gap", lat, 32'd5);
    repeat (3) @(negedge clk);
    check("t3_done_count", done_cnt4, 32'd4);

    // 4: 0x80 - 0x01 = 0x7F, start during BUSY ignored
    base = done_cnt8;
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    exp_q8.push_back({1'b0, 8'h7F});
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h01; start8 = 1'b1;
    check("t4_busy", {31'd0, busy8}, 32'd1);
    wait_done8(1'b1, lat, bcnt);
    check("t4_latency_rest", lat, 32'd6);
    repeat (12) @(negedge clk);
    check("t4_single_done", done_cnt8 - base, 32'd1);

    // 5: reset at the 3rd BUSY edge aborts without a done pulse
    base = done_cnt8;
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy",  {31'd0, busy8},  32'd0);
    check("t5_done",  {31'd0, done8},  32'd0);
    check("t5_diff",  {24'd0, diff8},  32'd0);
    check("t5_bout",  {31'd0, b_out8}, 32'd0);
    repeat (15) @(negedge clk);
    check("t5_no_done", done_cnt8 - base, 32'd0);
    run8(8'h20, 8'h10);

    // directed 8-bit boundary vectors
    run8(8'h00, 8'hFF);
    run8(8'hFF, 8'h00);
    run8(8'hAA, 8'hAA);
    run8(8'h00, 8'h01);

    // 6: randomised operations
    for (int i = 0; i < 1000; i++)
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    repeat (4) @(negedge clk);
    check("q4_drained", exp_q4.size(), 32'd0);
    check("q8_drained", exp_q8.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
